// File: rtl/aemb2_dwb_wbuf.sv
// Posted-write buffer between the core data bus and the external data bus.
// Writes are queued and acked at once; reads wait until the queue has drained.
module aemb2_dwb_wbuf #(
    parameter int AEMB_DWB  = 32,
    parameter int DEPTH_LOG = 2
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic [AEMB_DWB-1:2] dwb_adr_i,
    input  logic [31:0]         dwb_dat_i,
    input  logic [3:0]          dwb_sel_i,
    input  logic                dwb_wre_i,
    input  logic                dwb_stb_i,
    input  logic                dwb_cyc_i,
    input  logic                dwb_tag_i,
    output logic                dwb_ack_o,
    output logic [31:0]         dwb_dat_o,
    output logic [AEMB_DWB-1:2] mwb_adr_o,
    output logic [31:0]         mwb_dat_o,
    output logic [3:0]          mwb_sel_o,
    output logic                mwb_wre_o,
    output logic                mwb_stb_o,
    output logic                mwb_cyc_o,
    output logic                mwb_tag_o,
    input  logic                mwb_ack_i,
    input  logic [31:0]         mwb_dat_i,
    output logic                wbuf_empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD, RACK} state_t;
    state_t state_q, state_d;

    logic [AEMB_DWB-1:2]  fifoAdr_q [DEPTH];
    logic [31:0]          fifoDat_q [DEPTH];
    logic [3:0]           fifoSel_q [DEPTH];
    logic                 fifoTag_q [DEPTH];
    logic [DEPTH_LOG-1:0] wrPtr_q, rdPtr_q;
    logic [DEPTH_LOG:0]   count_q, count_d;

    logic [AEMB_DWB-1:2]  mwbAdr_q, mwbAdr_d;
    logic [31:0]          mwbDat_q, mwbDat_d;
    logic [3:0]           mwbSel_q, mwbSel_d;
    logic                 mwbWre_q, mwbWre_d;
    logic                 mwbStb_q, mwbStb_d;
    logic                 mwbCyc_q, mwbCyc_d;
    logic                 mwbTag_q, mwbTag_d;
    logic                 dwbAck_q, dwbAck_d;
    logic [31:0]          dwbDat_q, dwbDat_d;

    logic req, full, push, pop;

    // The ack term keeps a strobe held across its own ack from being taken twice.
    assign req  = dwb_stb_i & dwb_cyc_i & ~dwbAck_q;
    assign full = (count_q == DEPTH_CNT);
    assign push = req & dwb_wre_i & ~full;
    assign pop  = (state_q == WR) & mwb_ack_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge gclk) begin
        if (push) begin
            fifoAdr_q[wrPtr_q] <= dwb_adr_i;
            fifoDat_q[wrPtr_q] <= dwb_dat_i;
            fifoSel_q[wrPtr_q] <= dwb_sel_i;
            fifoTag_q[wrPtr_q] <= dwb_tag_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        mwbAdr_d = mwbAdr_q;
        mwbDat_d = mwbDat_q;
        mwbSel_d = mwbSel_q;
        mwbWre_d = mwbWre_q;
        mwbStb_d = mwbStb_q;
        mwbCyc_d = mwbCyc_q;
        mwbTag_d = mwbTag_q;
        dwbDat_d = dwbDat_q;
        dwbAck_d = push;
        unique case (state_q)
            // Draining queued writes always wins over a waiting read.
            IDLE: begin
                if (count_q != '0) begin
                    state_d  = WR;
                    mwbAdr_d = fifoAdr_q[rdPtr_q];
                    mwbDat_d = fifoDat_q[rdPtr_q];
                    mwbSel_d = fifoSel_q[rdPtr_q];
                    mwbTag_d = fifoTag_q[rdPtr_q];
                    mwbWre_d = 1'b1;
                    mwbStb_d = 1'b1;
                    mwbCyc_d = 1'b1;
                end else if (req && !dwb_wre_i) begin
                    state_d  = RD;
                    mwbAdr_d = dwb_adr_i;
                    mwbSel_d = dwb_sel_i;
                    mwbTag_d = dwb_tag_i;
                    mwbWre_d = 1'b0;
                    mwbStb_d = 1'b1;
                    mwbCyc_d = 1'b1;
                end
            end
            WR: begin
                if (mwb_ack_i) begin
                    state_d  = IDLE;
                    mwbStb_d = 1'b0;
                    mwbCyc_d = 1'b0;
                end
            end
            RD: begin
                if (mwb_ack_i) begin
                    state_d  = RACK;
                    mwbStb_d = 1'b0;
                    mwbCyc_d = 1'b0;
                    dwbDat_d = mwb_dat_i;
                    dwbAck_d = 1'b1;
                end
            end
            RACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            mwbAdr_q <= '0;
            mwbDat_q <= '0;
            mwbSel_q <= '0;
            mwbWre_q <= 1'b0;
            mwbStb_q <= 1'b0;
            mwbCyc_q <= 1'b0;
            mwbTag_q <= 1'b0;
            dwbAck_q <= 1'b0;
            dwbDat_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mwbAdr_q <= mwbAdr_d;
            mwbDat_q <= mwbDat_d;
            mwbSel_q <= mwbSel_d;
            mwbWre_q <= mwbWre_d;
            mwbStb_q <= mwbStb_d;
            mwbCyc_q <= mwbCyc_d;
            mwbTag_q <= mwbTag_d;
            dwbAck_q <= dwbAck_d;
            dwbDat_q <= dwbDat_d;
            if (push)
                wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)
                rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    assign dwb_ack_o  = dwbAck_q;
    assign dwb_dat_o  = dwbDat_q;
    assign mwb_adr_o  = mwbAdr_q;
    assign mwb_dat_o  = mwbDat_q;
    assign mwb_sel_o  = mwbSel_q;
    assign mwb_wre_o  = mwbWre_q;
    assign mwb_stb_o  = mwbStb_q;
    assign mwb_cyc_o  = mwbCyc_q;
    assign mwb_tag_o  = mwbTag_q;
    assign wbuf_empty = (count_q == '0);

endmodule

// File: tb/tb_aemb2_dwb_wbuf.sv
// Scoreboard bench for aemb2_dwb_wbuf: a memory-level model predicts every external
// bus transaction and every core read result; monitors compare as the DUT presents them.
module tb_aemb2_dwb_wbuf;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic [29:0] dwb_adr_i = '0;
    logic [31:0] dwb_dat_i = '0;
    logic [3:0]  dwb_sel_i = '0;
    logic        dwb_wre_i = 1'b0;
    logic        dwb_stb_i = 1'b0;
    logic        dwb_cyc_i = 1'b0;
    logic        dwb_tag_i = 1'b0;
    logic        dwb_ack_o;
    logic [31:0] dwb_dat_o;
    logic [29:0] mwb_adr_o;
    logic [31:0] mwb_dat_o;
    logic [3:0]  mwb_sel_o;
    logic        mwb_wre_o;
    logic        mwb_stb_o;
    logic        mwb_cyc_o;
    logic        mwb_tag_o;
    logic        mwb_ack_i = 1'b0;
    logic [31:0] mwb_dat_i = '0;
    logic        wbuf_empty;

    aemb2_dwb_wbuf #(.AEMB_DWB(32), .DEPTH_LOG(2)) dut (
        .gclk(gclk), .grst(grst),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_sel_i(dwb_sel_i),
        .dwb_wre_i(dwb_wre_i), .dwb_stb_i(dwb_stb_i), .dwb_cyc_i(dwb_cyc_i),
        .dwb_tag_i(dwb_tag_i), .dwb_ack_o(dwb_ack_o), .dwb_dat_o(dwb_dat_o),
        .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o), .mwb_sel_o(mwb_sel_o),
        .mwb_wre_o(mwb_wre_o), .mwb_stb_o(mwb_stb_o), .mwb_cyc_o(mwb_cyc_o),
        .mwb_tag_o(mwb_tag_o), .mwb_ack_i(mwb_ack_i), .mwb_dat_i(mwb_dat_i),
        .wbuf_empty(wbuf_empty)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        wre;
        logic        tag;
    } busTxn_t;

    typedef struct {
        logic        isRead;
        logic [31:0] dat;
    } coreResp_t;

    busTxn_t     mwbExpQ[$];
    coreResp_t   coreExpQ[$];
    logic [31:0] modelMem [logic [29:0]];
    logic [31:0] slaveMem [logic [29:0]];

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int slaveMode = 1;
    int lastSlaveAckCycle = -100;
    busTxn_t   slvExp;
    coreResp_t monResp;

    always @(posedge gclk) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] initVal(input logic [29:0] a);
        return 32'hA500_0000 ^ {a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldV, input logic [31:0] newV,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = oldV;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = newV[8*b +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic slaveReady();
        case (slaveMode)
            0:       return ($urandom_range(0, 1) == 1);
            2, 3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // External slave plus bus monitor: each accepted transaction is checked against the scoreboard.
    always @(negedge gclk) begin
        if (grst) begin
            mwb_ack_i = 1'b0;
        end else if (mwb_stb_o && mwb_cyc_o && !mwb_ack_i && slaveReady()) begin
            checkOutput("mwb_txn_expected", 32'(mwbExpQ.size() != 0), 32'd1);
            if (mwbExpQ.size() != 0) begin
                slvExp = mwbExpQ.pop_front();
                checkOutput("mwb_wre", 32'(mwb_wre_o), 32'(slvExp.wre));
                checkOutput("mwb_adr", 32'(mwb_adr_o), 32'(slvExp.adr));
                checkOutput("mwb_sel", 32'(mwb_sel_o), 32'(slvExp.sel));
                checkOutput("mwb_tag", 32'(mwb_tag_o), 32'(slvExp.tag));
                if (slvExp.wre)
                    checkOutput("mwb_dat", mwb_dat_o, slvExp.dat);
            end
            if (mwb_wre_o) begin
                slaveMem[mwb_adr_o] = mergeBytes(slaveMem.exists(mwb_adr_o) ? slaveMem[mwb_adr_o]
                                                 : initVal(mwb_adr_o), mwb_dat_o, mwb_sel_o);
                mwb_dat_i = $urandom;
            end else begin
                mwb_dat_i = slaveMem.exists(mwb_adr_o) ? slaveMem[mwb_adr_o] : initVal(mwb_adr_o);
            end
            mwb_ack_i = 1'b1;
            lastSlaveAckCycle = cycleCnt;
            if (slaveMode == 2) slaveMode = 1;
        end else begin
            mwb_ack_i = 1'b0;
            mwb_dat_i = $urandom;
        end
    end

    // Core-side monitor: every ack must match an outstanding request; reads carry data.
    always @(negedge gclk) begin
        if (!grst && dwb_ack_o) begin
            checkOutput("core_ack_expected", 32'(coreExpQ.size() != 0), 32'd1);
            if (coreExpQ.size() != 0) begin
                monResp = coreExpQ.pop_front();
                if (monResp.isRead)
                    checkOutput("rd_data", dwb_dat_o, monResp.dat);
            end
        end
    end

    task automatic applyStimulus(input logic wre, input logic [29:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic tag, input int maxWait,
                                 output logic acked, output int issueCyc, output int ackCyc);
        logic [31:0] rdExp;
        @(posedge gclk);
        #1;
        dwb_adr_i = adr;
        dwb_dat_i = dat;
        dwb_sel_i = sel;
        dwb_wre_i = wre;
        dwb_tag_i = tag;
        dwb_stb_i = 1'b1;
        dwb_cyc_i = 1'b1;
        issueCyc  = cycleCnt;
        if (wre) begin
            mwbExpQ.push_back('{adr, dat, sel, 1'b1, tag});
            coreExpQ.push_back('{1'b0, 32'h0});
        end else begin
            rdExp = modelMem.exists(adr) ? modelMem[adr] : initVal(adr);
            mwbExpQ.push_back('{adr, 32'h0, sel, 1'b0, tag});
            coreExpQ.push_back('{1'b1, rdExp});
        end
        acked  = 1'b0;
        ackCyc = -1;
        for (int i = 0; i < maxWait && !acked; i++) begin
            @(negedge gclk);
            if (dwb_ack_o) begin
                acked  = 1'b1;
                ackCyc = cycleCnt;
            end
        end
        if (acked && wre)
            modelMem[adr] = mergeBytes(modelMem.exists(adr) ? modelMem[adr] : initVal(adr), dat, sel);
        if (!acked) begin
            void'(mwbExpQ.pop_back());
            void'(coreExpQ.pop_back());
        end
        @(posedge gclk);
        #1;
        dwb_stb_i = 1'b0;
        dwb_cyc_i = 1'b0;
    endtask

    task automatic waitEmpty(input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge gclk);
            n++;
        end while (!(wbuf_empty && mwbExpQ.size() == 0 && !mwb_stb_o) && n < maxCycles);
        checkOutput("drain_empty", 32'(wbuf_empty), 32'd1);
        checkOutput("drain_scoreboard", 32'(mwbExpQ.size()), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        acked;
        int          iss, ack;
        logic [29:0] rAdr;
        logic        rWre;

        slaveMem[30'h20] = 32'h1234_5678;
        modelMem[30'h20] = 32'h1234_5678;

        // Reset and idle.
        repeat (3) @(posedge gclk);
        #1 grst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            checkOutput("rst_mwb_stb", 32'(mwb_stb_o), 32'd0);
            checkOutput("rst_mwb_cyc", 32'(mwb_cyc_o), 32'd0);
            checkOutput("rst_mwb_wre", 32'(mwb_wre_o), 32'd0);
            checkOutput("rst_dwb_ack", 32'(dwb_ack_o), 32'd0);
            checkOutput("rst_empty", 32'(wbuf_empty), 32'd1);
            checkOutput("rst_dwb_dat", dwb_dat_o, 32'd0);
        end

        // Single write.
        slaveMode = 3;
        applyStimulus(1'b1, 30'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 10, acked, iss, ack);
        checkOutput("single_wr_acked", 32'(acked), 32'd1);
        checkOutput("single_wr_lat", 32'(ack - iss), 32'd1);
        waitEmpty(50);

        // Burst of five with the external bus stalled.
        slaveMode = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 30'h100 + 30'(i), $urandom, 4'hF, i[0], 10, acked, iss, ack);
            checkOutput("burst_ack_lat", 32'(ack - iss), 32'd1);
        end
        fork
            applyStimulus(1'b1, 30'h104, 32'hCAFE_0005, 4'hF, 1'b0, 40, acked, iss, ack);
            begin
                repeat (6) @(posedge gclk);
                #1 slaveMode = 2;
            end
        join
        checkOutput("stall_acked", 32'(acked), 32'd1);
        checkOutput("stall_held", 32'((ack - iss) > 5), 32'd1);
        checkOutput("stall_release_lat", 32'(ack - lastSlaveAckCycle), 32'd2);
        slaveMode = 3;
        waitEmpty(100);

        // Two queued writes, then a read that must wait for them.
        slaveMode = 1;
        applyStimulus(1'b1, 30'h21, 32'h1111_1111, 4'hF, 1'b0, 10, acked, iss, ack);
        applyStimulus(1'b1, 30'h22, 32'h2222_2222, 4'h3, 1'b1, 10, acked, iss, ack);
        fork
            applyStimulus(1'b0, 30'h20, 32'h0, 4'hF, 1'b1, 60, acked, iss, ack);
            begin
                repeat (4) @(posedge gclk);
                #1 slaveMode = 3;
            end
        join
        checkOutput("rd_acked", 32'(acked), 32'd1);
        checkOutput("rd_ack_lat", 32'(ack - lastSlaveAckCycle), 32'd1);
        checkOutput("rd_dat_hold", dwb_dat_o, 32'h1234_5678);
        waitEmpty(50);

        // Read with an empty buffer reaches the external bus one cycle after the request.
        applyStimulus(1'b0, 30'h22, 32'h0, 4'hF, 1'b0, 20, acked, iss, ack);
        checkOutput("rd_issue_lat", 32'(lastSlaveAckCycle - iss), 32'd1);
        checkOutput("rd_merge_data", dwb_dat_o, mergeBytes(initVal(30'h22), 32'h2222_2222, 4'h3));

        // Push and pop in the same cycle at count 2, then confirm the count by filling up.
        slaveMode = 1;
        applyStimulus(1'b1, 30'h30, 32'hA0A0_0001, 4'hF, 1'b0, 10, acked, iss, ack);
        applyStimulus(1'b1, 30'h31, 32'hA0A0_0002, 4'hF, 1'b1, 10, acked, iss, ack);
        fork
            applyStimulus(1'b1, 30'h32, 32'hA0A0_0003, 4'hC, 1'b0, 10, acked, iss, ack);
            begin
                @(posedge gclk);
                #1 slaveMode = 2;
            end
        join
        checkOutput("pushpop_lat", 32'(ack - iss), 32'd1);
        checkOutput("pushpop_not_empty", 32'(wbuf_empty), 32'd0);
        applyStimulus(1'b1, 30'h33, 32'hA0A0_0004, 4'hF, 1'b1, 10, acked, iss, ack);
        checkOutput("fill3_acked", 32'(acked), 32'd1);
        applyStimulus(1'b1, 30'h34, 32'hA0A0_0005, 4'hF, 1'b0, 10, acked, iss, ack);
        checkOutput("fill4_acked", 32'(acked), 32'd1);
        applyStimulus(1'b1, 30'h35, 32'hA0A0_0006, 4'hF, 1'b0, 6, acked, iss, ack);
        checkOutput("full_stalls", 32'(acked), 32'd0);
        slaveMode = 3;
        waitEmpty(100);

        // Reset during an external write abandons it.
        slaveMode = 1;
        applyStimulus(1'b1, 30'h3F0, 32'h5555_AAAA, 4'hF, 1'b1, 10, acked, iss, ack);
        for (int i = 0; i < 10 && !mwb_stb_o; i++) @(negedge gclk);
        checkOutput("midrst_stb_seen", 32'(mwb_stb_o), 32'd1);
        @(posedge gclk);
        #1 grst = 1'b1;
        @(posedge gclk);
        #1;
        checkOutput("midrst_stb", 32'(mwb_stb_o), 32'd0);
        checkOutput("midrst_cyc", 32'(mwb_cyc_o), 32'd0);
        checkOutput("midrst_empty", 32'(wbuf_empty), 32'd1);
        checkOutput("midrst_ack", 32'(dwb_ack_o), 32'd0);
        grst = 1'b0;
        mwbExpQ.delete();
        slaveMode = 3;
        applyStimulus(1'b1, 30'h11, 32'h0BAD_F00D, 4'h5, 1'b0, 10, acked, iss, ack);
        checkOutput("postrst_wr_lat", 32'(ack - iss), 32'd1);
        waitEmpty(50);

        // Randomized traffic with a randomly stalling external bus.
        slaveMode = 0;
        for (int n = 0; n < 80; n++) begin
            rAdr = 30'h40 + 30'($urandom_range(0, 7));
            rWre = ($urandom_range(0, 9) < 7);
            applyStimulus(rWre, rAdr, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                          300, acked, iss, ack);
            checkOutput("rand_acked", 32'(acked), 32'd1);
            if (rWre && acked)
                checkOutput("rand_wr_lat_bound", 32'((ack - iss) >= 1), 32'd1);
            repeat ($urandom_range(0, 2)) @(posedge gclk);
        end
        slaveMode = 3;
        waitEmpty(200);
        repeat (2) @(negedge gclk);
        checkOutput("core_scoreboard_empty", 32'(coreExpQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
